// File: rtl/dio_spi_master.sv
// SPI master for the data_io side channel: wraps INDEX / START / END / DATA
// operations into SS2-framed byte sequences, MSB first, SCK idle low.
module dio_spi_master #(
    parameter int CLK_DIV = 2,   // clk_sys cycles per SCK half period (1..255)
    parameter int SS_GAP  = 4    // minimum SCK half periods SS2 stays high between operations
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_arg,
    input  logic [15:0] cmd_len,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        done,
    output logic [7:0]  status,
    output logic        SPI_SCK,
    output logic        SPI_SS2,
    output logic        SPI_DI,
    input  logic        SPI_DO
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, LOAD, WAIT_DATA, FINISH, GAP} state_e;

    localparam logic [1:0]  OP_INDEX = 2'd0;
    localparam logic [1:0]  OP_START = 2'd1;
    localparam logic [1:0]  OP_END   = 2'd2;
    localparam logic [1:0]  OP_DATA  = 2'd3;
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_N    = 16'(SS_GAP);

    state_e      state_q;
    logic [7:0]  div_q;        // position inside the current half period
    logic [7:0]  tx_q;         // outgoing byte, bit 7 is on SPI_DI
    logic [7:0]  rx_q;         // bits sampled from SPI_DO
    logic [7:0]  arg_q;
    logic [7:0]  status_q;
    logic [2:0]  bit_q;        // bits completed in the current byte
    logic [15:0] cnt_q;        // bytes still to send after the current one
    logic [15:0] gap_q;        // half periods of SS2-high left in GAP
    logic [1:0]  op_q;
    logic        first_q;      // current byte is the command byte
    logic        sck_q, ss_q, di_q, done_q, cmd_ready_q;
    logic        tick;
    logic [7:0]  first_byte_d;
    logic [7:0]  next_byte_d;

    assign tick = (div_q == DIV_LAST);

    // Command byte for the incoming request and the follow-on byte for the latched one
    always_comb begin
        first_byte_d = 8'h53;
        case (cmd_op)
            OP_INDEX: first_byte_d = 8'h55;
            OP_DATA:  first_byte_d = 8'h54;
            default:  first_byte_d = 8'h53;
        endcase
        next_byte_d = in_data;
        case (op_q)
            OP_INDEX: next_byte_d = arg_q;
            OP_START: next_byte_d = 8'h01;
            OP_END:   next_byte_d = 8'h00;
            default:  next_byte_d = in_data;
        endcase
    end

    // Payload handshake is live only while LOAD is waiting on a DATA byte
    assign in_ready  = (state_q == LOAD) && (op_q == OP_DATA) && in_valid;
    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign status    = status_q;
    assign SPI_SCK   = sck_q;
    assign SPI_SS2   = ss_q;
    assign SPI_DI    = di_q;

    // Sequencer: frames the bytes, generates SCK and shifts both directions
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            arg_q       <= '0;
            status_q    <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            op_q        <= OP_INDEX;
            first_q     <= 1'b0;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            di_q        <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div_q  <= tick ? '0 : div_q + 8'd1;
            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= cmd_op;
                        arg_q       <= cmd_arg;
                        cnt_q       <= (cmd_op == OP_DATA) ? cmd_len : 16'd1;
                        tx_q        <= first_byte_d;
                        di_q        <= first_byte_d[7];
                        ss_q        <= 1'b0;
                        sck_q       <= 1'b0;
                        bit_q       <= '0;
                        first_q     <= 1'b1;
                        state_q     <= SETUP;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sck_q   <= 1'b1;
                        rx_q    <= {rx_q[6:0], SPI_DO};
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            rx_q  <= {rx_q[6:0], SPI_DO};
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_q == 3'd7) begin
                                bit_q   <= '0;
                                first_q <= 1'b0;
                                if (first_q) status_q <= rx_q;
                                if (cnt_q != 16'd0) begin
                                    state_q <= LOAD;
                                end else begin
                                    di_q    <= 1'b0;
                                    state_q <= FINISH;
                                end
                            end else begin
                                bit_q <= bit_q + 3'd1;
                                tx_q  <= {tx_q[6:0], 1'b0};
                                di_q  <= tx_q[6];
                            end
                        end
                    end
                end
                // One SCK-low cycle to fetch the next byte; the half period restarts after it
                LOAD: begin
                    div_q <= '0;
                    if (op_q != OP_DATA || in_valid) begin
                        tx_q    <= next_byte_d;
                        di_q    <= next_byte_d[7];
                        cnt_q   <= cnt_q - 16'd1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    div_q <= '0;
                    if (in_valid) state_q <= LOAD;
                end
                // Trailing SCK-low half period before SS2 is released
                FINISH: begin
                    if (tick) begin
                        ss_q    <= 1'b1;
                        done_q  <= 1'b1;
                        gap_q   <= GAP_N;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q == 16'd0) begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (tick) begin
                        gap_q <= gap_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
